// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: select codes, default widths,
// occupancy states and the buffered issue-entry layout.
package alu_pkg;

   localparam int unsigned ALU_DATA_W = 32;
   localparam int unsigned ALU_IDX_W  = 5;
   localparam int unsigned ALU_IMM_W  = 16;

   localparam logic [2:0] ALU_PASS   = 3'b000;
   localparam logic [2:0] ALU_SUB    = 3'b001;
   localparam logic [2:0] ALU_ADD    = 3'b010;
   localparam logic [2:0] ALU_SLT    = 3'b011;
   localparam logic [2:0] ALU_XOR    = 3'b100;
   localparam logic [2:0] ALU_NEGADD = 3'b101;
   localparam logic [2:0] ALU_MUL    = 3'b110;
   localparam logic [2:0] ALU_ZERO   = 3'b111;

   typedef enum logic [1:0] {
      OCC_EMPTY,
      OCC_ONE,
      OCC_TWO
   } occ_t;

   typedef struct packed {
      logic [2:0]            op;
      logic [ALU_IDX_W-1:0]  rd;
      logic [ALU_IDX_W-1:0]  rs_a;
      logic [ALU_IDX_W-1:0]  rs_b;
      logic                  use_imm;
      logic [ALU_DATA_W-1:0] a;
      logic [ALU_DATA_W-1:0] b;
   } issue_entry_t;

   localparam issue_entry_t ENTRY_RST = '{op: ALU_ZERO, default: '0};

   function automatic logic [ALU_DATA_W-1:0] sext_imm(input logic [ALU_IMM_W-1:0] imm);
      return {{(ALU_DATA_W-ALU_IMM_W){imm[ALU_IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/alu_fwd_mux.sv
// Write-back forwarding for one operand; index 0 and immediate operands are
// never replaced.
module alu_fwd_mux
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned IDX_W  = ALU_IDX_W
) (
   input  logic [IDX_W-1:0]  idx,
   input  logic              use_imm,
   input  logic [DATA_W-1:0] data,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] q
);

   always_comb begin
      q = data;
      if (wb_valid && !use_imm && (idx != '0) && (wb_rd == idx)) begin
         q = wb_data;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage ahead of the ALU: two-entry (output + skid) buffer with
// capture-time forwarding and continuous write-back refresh of held operands.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned DATA_W = ALU_DATA_W,
   parameter int unsigned IDX_W  = ALU_IDX_W,
   parameter int unsigned IMM_W  = ALU_IMM_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [IDX_W-1:0]  in_rs_a,
   input  logic [IDX_W-1:0]  in_rs_b,
   input  logic [IDX_W-1:0]  in_rd,
   input  logic [DATA_W-1:0] in_a_data,
   input  logic [DATA_W-1:0] in_b_data,
   input  logic [IMM_W-1:0]  in_imm,
   input  logic              in_use_imm,
   input  logic              wb_valid,
   input  logic [IDX_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_a,
   output logic [DATA_W-1:0] out_b,
   output logic [2:0]        out_select,
   output logic [IDX_W-1:0]  out_rd
);

   occ_t         state_q, state_d;
   issue_entry_t out_q, out_d, skid_q, skid_d;
   logic         in_ready_q;
   logic         accept, present;

   // Slot 0 is the incoming op, slot 1 the output register, slot 2 the skid.
   issue_entry_t      src   [3];
   issue_entry_t      fresh [3];
   logic [DATA_W-1:0] fa    [3];
   logic [DATA_W-1:0] fb    [3];

   assign src[0] = '{op:      in_op,
                     rd:      in_rd,
                     rs_a:    in_rs_a,
                     rs_b:    in_rs_b,
                     use_imm: in_use_imm,
                     a:       in_a_data,
                     b:       in_use_imm ? sext_imm(in_imm) : in_b_data};
   assign src[1] = out_q;
   assign src[2] = skid_q;

   for (genvar g = 0; g < 3; g++) begin : g_fwd
      alu_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_fwd_a (
         .idx      (src[g].rs_a),
         .use_imm  (1'b0),
         .data     (src[g].a),
         .wb_valid (wb_valid),
         .wb_rd    (wb_rd),
         .wb_data  (wb_data),
         .q        (fa[g])
      );
      alu_fwd_mux #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_fwd_b (
         .idx      (src[g].rs_b),
         .use_imm  (src[g].use_imm),
         .data     (src[g].b),
         .wb_valid (wb_valid),
         .wb_rd    (wb_rd),
         .wb_data  (wb_data),
         .q        (fb[g])
      );
   end

   always_comb begin
      for (int unsigned i = 0; i < 3; i++) begin
         fresh[i]   = src[i];
         fresh[i].a = fa[i];
         fresh[i].b = fb[i];
      end
   end

   assign accept  = in_valid & in_ready_q & ~flush;
   assign present = (state_q != OCC_EMPTY) & out_ready;

   // A presented entry leaves with its pre-edge value; only survivors take the refresh.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = OCC_EMPTY;
      end else begin
         case (state_q)
            OCC_EMPTY: begin
               if (accept) begin
                  out_d   = fresh[0];
                  state_d = OCC_ONE;
               end
            end
            OCC_ONE: begin
               out_d = fresh[1];
               if (accept && present) begin
                  out_d = fresh[0];
               end else if (accept) begin
                  skid_d  = fresh[0];
                  state_d = OCC_TWO;
               end else if (present) begin
                  state_d = OCC_EMPTY;
               end
            end
            OCC_TWO: begin
               out_d  = fresh[1];
               skid_d = fresh[2];
               if (present) begin
                  out_d   = fresh[2];
                  state_d = OCC_ONE;
               end
            end
            default: state_d = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= OCC_EMPTY;
         in_ready_q <= 1'b1;
         out_q      <= ENTRY_RST;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= (state_d != OCC_TWO);
         out_q      <= out_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != OCC_EMPTY);
   assign out_a      = out_q.a;
   assign out_b      = out_q.b;
   assign out_select = out_q.op;
   assign out_rd     = out_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus randomized traffic
// checked against a two-deep FIFO model of the stage.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic [4:0]  in_rs_a, in_rs_b, in_rd;
   logic [31:0] in_a_data, in_b_data;
   logic [15:0] in_imm;
   logic        in_use_imm;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a, out_b;
   logic [2:0]  out_select;
   logic [4:0]  out_rd;

   always #5 clk = ~clk;

   alu_issue_stage #(.DATA_W(32), .IDX_W(5), .IMM_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_rs_a    (in_rs_a),
      .in_rs_b    (in_rs_b),
      .in_rd      (in_rd),
      .in_a_data  (in_a_data),
      .in_b_data  (in_b_data),
      .in_imm     (in_imm),
      .in_use_imm (in_use_imm),
      .wb_valid   (wb_valid),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_a      (out_a),
      .out_b      (out_b),
      .out_select (out_select),
      .out_rd     (out_rd)
   );

   typedef struct {
      logic [2:0]  op;
      logic [4:0]  rd, rs_a, rs_b;
      logic        use_imm;
      logic [31:0] a, b;
   } mop_t;

   mop_t mq[$];
   logic exp_ready;
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
      return (wb_valid && wb_rd == idx && idx != 5'd0) ? wb_data : d;
   endfunction

   // One clock: the model consumes the pre-edge inputs, then outputs settle.
   task automatic tick();
      mop_t n;
      logic acc, pres;
      @(posedge clk);
      pres = (mq.size() != 0) && out_ready;
      acc  = in_valid && exp_ready && !flush;
      if (flush) begin
         mq.delete();
      end else begin
         if (pres) void'(mq.pop_front());
         foreach (mq[i]) begin
            mq[i].a = fwd(mq[i].rs_a, mq[i].a);
            if (!mq[i].use_imm) mq[i].b = fwd(mq[i].rs_b, mq[i].b);
         end
         if (acc) begin
            n.op = in_op; n.rd = in_rd; n.rs_a = in_rs_a; n.rs_b = in_rs_b;
            n.use_imm = in_use_imm;
            n.a = fwd(in_rs_a, in_a_data);
            n.b = in_use_imm ? {{16{in_imm[15]}}, in_imm} : fwd(in_rs_b, in_b_data);
            mq.push_back(n);
         end
      end
      exp_ready = (mq.size() < 2);
      #1;
   endtask

   task automatic idle();
      in_valid = 1'b0; flush = 1'b0; wb_valid = 1'b0;
   endtask

   task automatic drive_op(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] ra,
                           input logic [4:0] rb, input logic [31:0] a, input logic [31:0] b,
                           input logic ui, input logic [15:0] imm);
      in_valid = 1'b1; in_op = op; in_rd = rd; in_rs_a = ra; in_rs_b = rb;
      in_a_data = a; in_b_data = b; in_use_imm = ui; in_imm = imm;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; idle(); out_ready = 1'b0;
      in_op = '0; in_rs_a = '0; in_rs_b = '0; in_rd = '0; in_a_data = '0;
      in_b_data = '0; in_imm = '0; in_use_imm = 1'b0; wb_rd = '0; wb_data = '0;
      mq.delete(); exp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      total++; if (out_a !== 32'h0 || out_b !== 32'h0) begin bad++; $display("FAIL reset_ab got=%h/%h exp=0/0", out_a, out_b); end
      total++; if (out_select !== 3'b111 || out_rd !== 5'd0) begin bad++; $display("FAIL reset_sel_rd got=%b/%0d exp=111/0", out_select, out_rd); end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_single();
      out_ready = 1'b1;
      drive_op(3'b010, 5'd4, 5'd1, 5'd2, 32'd5, 32'd7, 1'b0, 16'h0);
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", out_valid); end
      total++; if (out_a !== 32'd5 || out_b !== 32'd7) begin bad++; $display("FAIL single_ab got=%0d/%0d exp=5/7", out_a, out_b); end
      total++; if (out_select !== 3'b010 || out_rd !== 5'd4) begin bad++; $display("FAIL single_sel_rd got=%b/%0d exp=010/4", out_select, out_rd); end
      idle();
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got[$];
      out_ready = 1'b0;
      drive_op(3'b001, 5'd10, 5'd1, 5'd2, 32'd100, 32'd200, 1'b0, 16'h0);
      tick();
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
      drive_op(3'b100, 5'd11, 5'd1, 5'd2, 32'd101, 32'd201, 1'b0, 16'h0);
      tick();
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL b2b_ready2 got=%b exp=0", in_ready); end
      drive_op(3'b110, 5'd12, 5'd1, 5'd2, 32'd102, 32'd202, 1'b0, 16'h0);
      tick();
      total++; if (in_ready !== 1'b0 || out_a !== 32'd100) begin bad++; $display("FAIL b2b_stall got=%b/%0d exp=0/100", in_ready, out_a); end
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         logic take;
         if (out_valid) got.push_back(out_a);
         take = in_valid && in_ready;
         tick();
         if (take) in_valid = 1'b0;
      end
      total++; if (got.size() != 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", got.size()); end
      foreach (got[i]) begin
         total++; if (got[i] !== 32'(100 + i)) begin bad++; $display("FAIL b2b_order got=%0d exp=%0d", got[i], 100 + i); end
      end
      total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got=%b/%b exp=1/0", in_ready, out_valid); end
   endtask

   task automatic test_forward();
      out_ready = 1'b1;
      drive_op(3'b000, 5'd1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 16'h0);
      wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
      tick();
      total++; if (out_a !== 32'hDEADBEEF || out_b !== 32'h22) begin bad++; $display("FAIL fwd_hit got=%h/%h exp=deadbeef/00000022", out_a, out_b); end
      drive_op(3'b000, 5'd1, 5'd0, 5'd4, 32'h33, 32'h44, 1'b0, 16'h0);
      wb_rd = 5'd0;
      tick();
      total++; if (out_a !== 32'h33) begin bad++; $display("FAIL fwd_zero got=%h exp=00000033", out_a); end
      idle();
      tick();
   endtask

   task automatic test_refresh();
      for (int u = 0; u < 2; u++) begin
         logic [31:0] exp_b;
         exp_b = (u == 0) ? 32'h12 : 32'hFFFFFFFF;
         out_ready = 1'b0;
         drive_op(3'b010, 5'd2, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 16'h0);
         tick();
         drive_op(3'b011, 5'd7, 5'd5, 5'd9, 32'hA5, 32'h55, u[0], 16'hFFFF);
         tick();
         idle();
         wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h12;
         tick();
         wb_valid = 1'b0; out_ready = 1'b1;
         tick();
         total++; if (out_valid !== 1'b1 || out_a !== 32'hA5) begin bad++; $display("FAIL refresh_a%0d got=%b/%h exp=1/000000a5", u, out_valid, out_a); end
         total++; if (out_b !== exp_b) begin bad++; $display("FAIL refresh_b%0d got=%h exp=%h", u, out_b, exp_b); end
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL refresh_drain%0d got=%b exp=0", u, out_valid); end
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive_op(3'b010, 5'd3, 5'd1, 5'd2, 32'h1, 32'h2, 1'b0, 16'h0);
      tick();
      drive_op(3'b010, 5'd4, 5'd1, 5'd2, 32'h3, 32'h4, 1'b0, 16'h0);
      tick();
      drive_op(3'b010, 5'd5, 5'd1, 5'd2, 32'h5, 32'h6, 1'b0, 16'h0);
      flush = 1'b1;
      tick();
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got=%b/%b exp=0/1", out_valid, in_ready); end
      idle(); out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost got=%b exp=0", out_valid); end
      end
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      drive_op(3'b110, 5'd8, 5'd1, 5'd2, 32'h77, 32'h88, 1'b0, 16'h0);
      tick();
      drive_op(3'b100, 5'd9, 5'd1, 5'd2, 32'h99, 32'hAA, 1'b0, 16'h0);
      tick();
      idle();
      rst_n = 1'b0; mq.delete(); exp_ready = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL areset_hs got=%b/%b exp=0/1", out_valid, in_ready); end
      total++; if (out_a !== 32'h0 || out_b !== 32'h0 || out_select !== 3'b111 || out_rd !== 5'd0) begin
         bad++; $display("FAIL areset_out got=%h/%h/%b/%0d exp=0/0/111/0", out_a, out_b, out_select, out_rd); end
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL areset_ghost got=%b exp=0", out_valid); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         in_valid   = ($urandom_range(0, 3) != 0);
         out_ready  = ($urandom_range(0, 2) != 0);
         flush      = ($urandom_range(0, 24) == 0);
         wb_valid   = ($urandom_range(0, 1) == 1);
         wb_rd      = 5'($urandom_range(0, 3));
         wb_data    = $urandom;
         in_op      = 3'($urandom_range(0, 7));
         in_rd      = 5'($urandom_range(0, 31));
         in_rs_a    = 5'($urandom_range(0, 3));
         in_rs_b    = 5'($urandom_range(0, 3));
         in_a_data  = $urandom;
         in_b_data  = $urandom;
         in_imm     = 16'($urandom);
         in_use_imm = ($urandom_range(0, 3) == 0);
         tick();
         total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, out_valid, mq.size() != 0); end
         total++; if (in_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, in_ready, exp_ready); end
         if (mq.size() != 0) begin
            total++; if (out_a !== mq[0].a || out_b !== mq[0].b) begin
               bad++; $display("FAIL rnd_ab c=%0d got=%h/%h exp=%h/%h", c, out_a, out_b, mq[0].a, mq[0].b); end
            total++; if (out_select !== mq[0].op || out_rd !== mq[0].rd) begin
               bad++; $display("FAIL rnd_sel_rd c=%0d got=%b/%0d exp=%b/%0d", c, out_select, out_rd, mq[0].op, mq[0].rd); end
         end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_forward();
      test_refresh();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
